backup_ram_ctrl: RTL and testbench



---
 rtl/backup_ram_pkg.sv | 17 +
 rtl/backup_ram_lane.sv | 34 +++
 rtl/backup_ram_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_backup_ram_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/backup_ram_pkg.sv
// Shared types and constants for the clocked 68K backup-RAM controller.
package backup_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACK   = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam int WAIT_CNT_W = 4;

  function automatic int lanesOf(input int dataW);
    return dataW / 8;
  endfunction

endpackage

// File: rtl/backup_ram_lane.sv
// One byte lane of backup storage: synchronous write, registered read with hold.
module backup_ram_lane #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] memR [2**ADDR_W];

  // Storage array; deliberately not reset so contents survive RESET.
  always_ff @(posedge clk) begin
    if (we) begin
      memR[addr] <= wdata;
    end
  end

  // Read register: a lane written in the same cycle returns the new byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 8'h00;
    end else if (re) begin
      rdata <= we ? wdata : memR[addr];
    end else begin
      rdata <= rdata;
    end
  end

endmodule

// File: rtl/backup_ram_ctrl.sv
// 68K backup-RAM controller: access FSM with wait states and nDTACK,
// write-protect latch and a one-word-per-cycle clear engine.
module backup_ram_ctrl
  import backup_ram_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter int          ADDR_W      = 15,
  parameter int          WAIT_STATES = 1,
  parameter logic [7:0]  INIT_BYTE   = 8'h00
) (
  input  logic                        CLK_24M,
  input  logic                        RESET,
  input  logic [ADDR_W-1:0]           M68K_ADDR,
  input  logic [DATA_W-1:0]           M68K_DATA_IN,
  output logic [DATA_W-1:0]           M68K_DATA_OUT,
  input  logic                        nCE,
  input  logic [lanesOf(DATA_W)-1:0]  nOE,
  input  logic [lanesOf(DATA_W)-1:0]  nWE,
  output logic                        nDTACK,
  input  logic                        WP_SET,
  input  logic                        WP_CLR,
  output logic                        WP_STATE,
  input  logic                        CLEAR_REQ,
  output logic                        CLEAR_BUSY
);

  localparam int LANES = lanesOf(DATA_W);
  localparam int DEPTH = 2**ADDR_W;
  localparam int CW    = ADDR_W + 1;
  localparam int WL    = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [CW-1:0]         CLR_LAST  = CW'(DEPTH - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WL);
  localparam logic                  NO_WAIT   = (WAIT_STATES == 0);

  state_t                  stateR;
  logic [WAIT_CNT_W-1:0]   waitCntR;
  logic [CW-1:0]           clrCntR;
  logic [ADDR_W-1:0]       addrR;
  logic [DATA_W-1:0]       dataR;
  logic [LANES-1:0]        oeR;
  logic [LANES-1:0]        weR;
  logic                    dtackNR;
  logic                    wpR;
  logic                    busyR;

  logic                    reqS;
  logic                    commitS;
  logic [ADDR_W-1:0]       ramAddrS;
  logic [DATA_W-1:0]       wdataS;
  logic [LANES-1:0]        oeSelS;
  logic [LANES-1:0]        weSelS;
  logic [LANES-1:0]        laneWeS;
  logic [LANES-1:0]        laneReS;

  assign reqS = ~nCE & ((|(~nOE)) | (|(~nWE)));

  // With no wait states the accepting edge is also the commit edge, so the
  // RAM sees the live bus in IDLE and the captured copy afterwards.
  assign commitS = ((stateR == IDLE) & ~CLEAR_REQ & reqS & NO_WAIT) |
                   ((stateR == WAIT) & (waitCntR == {WAIT_CNT_W{1'b0}}));

  // RAM address/data/strobe source selection.
  always_comb begin
    ramAddrS = addrR;
    wdataS   = dataR;
    oeSelS   = oeR;
    weSelS   = weR;
    case (stateR)
      IDLE: begin
        ramAddrS = M68K_ADDR;
        wdataS   = M68K_DATA_IN;
        oeSelS   = ~nOE;
        weSelS   = ~nWE;
      end
      CLEAR: begin
        ramAddrS = clrCntR[ADDR_W-1:0];
        wdataS   = {LANES{INIT_BYTE}};
      end
      default: begin
        ramAddrS = addrR;
      end
    endcase
  end

  // Per-lane enables; RESET suppresses any commit in its cycle.
  always_comb begin
    laneWeS = {LANES{1'b0}};
    laneReS = {LANES{1'b0}};
    for (int l = 0; l < LANES; l++) begin
      laneWeS[l] = ~RESET & ((stateR == CLEAR) | (commitS & weSelS[l] & ~wpR));
      laneReS[l] = ~RESET & commitS & oeSelS[l];
    end
  end

  // Access / clear state machine with registered handshake outputs.
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      stateR   <= IDLE;
      waitCntR <= {WAIT_CNT_W{1'b0}};
      clrCntR  <= {CW{1'b0}};
      addrR    <= {ADDR_W{1'b0}};
      dataR    <= {DATA_W{1'b0}};
      oeR      <= {LANES{1'b0}};
      weR      <= {LANES{1'b0}};
      dtackNR  <= 1'b1;
      busyR    <= 1'b0;
    end else begin
      case (stateR)
        IDLE: begin
          if (CLEAR_REQ) begin
            stateR  <= CLEAR;
            clrCntR <= {CW{1'b0}};
            busyR   <= 1'b1;
          end else if (reqS) begin
            addrR    <= M68K_ADDR;
            dataR    <= M68K_DATA_IN;
            oeR      <= ~nOE;
            weR      <= ~nWE;
            waitCntR <= WAIT_LOAD;
            if (NO_WAIT) begin
              stateR  <= ACK;
              dtackNR <= 1'b0;
            end else begin
              stateR <= WAIT;
            end
          end else begin
            stateR <= IDLE;
          end
        end
        WAIT: begin
          if (waitCntR == {WAIT_CNT_W{1'b0}}) begin
            stateR  <= ACK;
            dtackNR <= 1'b0;
          end else begin
            waitCntR <= waitCntR - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ACK: begin
          if (nCE) begin
            stateR  <= IDLE;
            dtackNR <= 1'b1;
          end else begin
            stateR <= ACK;
          end
        end
        CLEAR: begin
          clrCntR <= clrCntR + {{(CW-1){1'b0}}, 1'b1};
          if (clrCntR == CLR_LAST) begin
            stateR <= IDLE;
            busyR  <= 1'b0;
          end else begin
            stateR <= CLEAR;
          end
        end
        default: begin
          stateR  <= IDLE;
          dtackNR <= 1'b1;
          busyR   <= 1'b0;
        end
      endcase
    end
  end

  // Write-protect latch; set wins over clear, locked out of reset.
  always_ff @(posedge CLK_24M) begin
    if (RESET) begin
      wpR <= 1'b1;
    end else if (WP_SET) begin
      wpR <= 1'b1;
    end else if (WP_CLR) begin
      wpR <= 1'b0;
    end else begin
      wpR <= wpR;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : gLane
    backup_ram_lane #(.ADDR_W(ADDR_W)) uLane (
      .clk   (CLK_24M),
      .rst   (RESET),
      .we    (laneWeS[l]),
      .re    (laneReS[l]),
      .addr  (ramAddrS),
      .wdata (wdataS[8*l +: 8]),
      .rdata (M68K_DATA_OUT[8*l +: 8])
    );
  end

  assign nDTACK     = dtackNR;
  assign WP_STATE   = wpR;
  assign CLEAR_BUSY = busyR;

endmodule

// File: tb/tb_backup_ram_ctrl.sv
// Self-checking bench: three controller builds (WS=0/1/3) against a word-array model.
module tb_backup_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  addr = 10'h000;
  logic [15:0] din = 16'h0000;
  logic [1:0]  nOE = 2'b11;
  logic [1:0]  nWE = 2'b11;
  logic [2:0]  nCE = 3'b111;
  logic        wpSet = 1'b0;
  logic        wpClr = 1'b0;
  logic [2:0]  clrReq = 3'b000;
  logic [15:0] dout [3];
  logic [2:0]  nDtack;
  logic [2:0]  wpSt;
  logic [2:0]  busy;

  logic [15:0] mem [3][1024];
  logic [15:0] doutM [3];
  logic        wpM;
  int          nChecks = 0;
  int          nFail = 0;

  always #5 clk = ~clk;

  backup_ram_ctrl #(.DATA_W(16), .ADDR_W(4), .WAIT_STATES(0), .INIT_BYTE(8'h00)) dut0 (
    .CLK_24M(clk), .RESET(rst), .M68K_ADDR(addr[3:0]), .M68K_DATA_IN(din),
    .M68K_DATA_OUT(dout[0]), .nCE(nCE[0]), .nOE(nOE), .nWE(nWE), .nDTACK(nDtack[0]),
    .WP_SET(wpSet), .WP_CLR(wpClr), .WP_STATE(wpSt[0]), .CLEAR_REQ(clrReq[0]),
    .CLEAR_BUSY(busy[0]));

  backup_ram_ctrl #(.DATA_W(16), .ADDR_W(10), .WAIT_STATES(1), .INIT_BYTE(8'h00)) dut1 (
    .CLK_24M(clk), .RESET(rst), .M68K_ADDR(addr), .M68K_DATA_IN(din),
    .M68K_DATA_OUT(dout[1]), .nCE(nCE[1]), .nOE(nOE), .nWE(nWE), .nDTACK(nDtack[1]),
    .WP_SET(wpSet), .WP_CLR(wpClr), .WP_STATE(wpSt[1]), .CLEAR_REQ(clrReq[1]),
    .CLEAR_BUSY(busy[1]));

  backup_ram_ctrl #(.DATA_W(16), .ADDR_W(4), .WAIT_STATES(3), .INIT_BYTE(8'h00)) dut2 (
    .CLK_24M(clk), .RESET(rst), .M68K_ADDR(addr[3:0]), .M68K_DATA_IN(din),
    .M68K_DATA_OUT(dout[2]), .nCE(nCE[2]), .nOE(nOE), .nWE(nWE), .nDTACK(nDtack[2]),
    .WP_SET(wpSet), .WP_CLR(wpClr), .WP_STATE(wpSt[2]), .CLEAR_REQ(clrReq[2]),
    .CLEAR_BUSY(busy[2]));

  function automatic int wsOf(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  function automatic int depthOf(input int d);
    return (d == 1) ? 1024 : 16;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle on DUT d; model applies writes (unless locked) then lane reads.
  task automatic access(input int d, input logic [9:0] a, input logic [15:0] data,
                        input logic [1:0] oeN, input logic [1:0] weN,
                        input int expLat, input int hold);
    int lat;
    logic acked;
    int am;
    am = int'(a) % depthOf(d);
    @(negedge clk);
    addr = 10'(am);
    din = data;
    nOE = oeN;
    nWE = weN;
    nCE[d] = 1'b0;
    lat = 0;
    acked = 1'b0;
    for (int i = 0; i < 3000 && !acked; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (nDtack[d] == 1'b0) acked = 1'b1;
    end
    check("dtack_seen", {31'd0, acked}, 32'd1);
    if (expLat >= 0) check("dtack_latency", lat, expLat);
    for (int l = 0; l < 2; l++) begin
      if (!weN[l] && !wpM) mem[d][am][8*l +: 8] = data[8*l +: 8];
    end
    for (int l = 0; l < 2; l++) begin
      if (!oeN[l]) doutM[d][8*l +: 8] = mem[d][am][8*l +: 8];
    end
    check("dout_model", {16'd0, dout[d]}, {16'd0, doutM[d]});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      din = ~data;
      @(posedge clk);
      #1;
      check("dtack_hold", {31'd0, nDtack[d]}, 32'd0);
    end
    @(negedge clk);
    nCE[d] = 1'b1;
    nOE = 2'b11;
    nWE = 2'b11;
    @(posedge clk);
    #1;
    check("dtack_release", {31'd0, nDtack[d]}, 32'd1);
  endtask

  task automatic pulseWp(input logic s, input logic c);
    @(negedge clk);
    wpSet = s;
    wpClr = c;
    @(posedge clk);
    #1;
    wpSet = 1'b0;
    wpClr = 1'b0;
    if (s) wpM = 1'b1;
    else if (c) wpM = 1'b0;
    for (int d = 0; d < 3; d++) check("wp_state", {31'd0, wpSt[d]}, {31'd0, wpM});
  endtask

  task automatic startClear(input int d);
    @(negedge clk);
    clrReq[d] = 1'b1;
    @(posedge clk);
    #1;
    clrReq[d] = 1'b0;
  endtask

  typedef struct {
    int          d;
    logic [9:0]  a;
    logic [15:0] data;
    logic [1:0]  oeN;
    logic [1:0]  weN;
    logic [15:0] expOut;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int cnt;
    vecs[0] = '{1, 10'h123, 16'hA55A, 2'b11, 2'b00, 16'h0000};
    vecs[1] = '{1, 10'h123, 16'h0000, 2'b00, 2'b11, 16'hA55A};
    vecs[2] = '{1, 10'h010, 16'h1234, 2'b11, 2'b00, 16'hA55A};
    vecs[3] = '{1, 10'h010, 16'h7E00, 2'b11, 2'b01, 16'hA55A};
    vecs[4] = '{1, 10'h010, 16'h0000, 2'b00, 2'b11, 16'h7E34};
    vecs[5] = '{1, 10'h123, 16'h0000, 2'b10, 2'b11, 16'h7E5A};
    vecs[6] = '{1, 10'h055, 16'hC3C3, 2'b00, 2'b00, 16'hC3C3};
    vecs[7] = '{1, 10'h123, 16'h0000, 2'b01, 2'b11, 16'hA5C3};
    vecs[8] = '{0, 10'h007, 16'h0F0F, 2'b11, 2'b00, 16'h0000};
    vecs[9] = '{0, 10'h007, 16'h0000, 2'b00, 2'b11, 16'h0F0F};

    wpM = 1'b1;
    for (int d = 0; d < 3; d++) doutM[d] = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check("rst_dout", {16'd0, dout[d]}, 32'd0);
      check("rst_dtack", {31'd0, nDtack[d]}, 32'd1);
      check("rst_wp", {31'd0, wpSt[d]}, 32'd1);
      check("rst_busy", {31'd0, busy[d]}, 32'd0);
    end

    // Bring every RAM to a known all-zero state.
    @(negedge clk);
    clrReq = 3'b111;
    @(posedge clk);
    #1;
    clrReq = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      if (busy == 3'b000) break;
      @(posedge clk);
      #1;
    end
    check("init_clear_done", {29'd0, busy}, 32'd0);
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 1024; i++) mem[d][i] = 16'h0000;

    pulseWp(1'b0, 1'b1);
    for (int v = 0; v < 10; v++) begin
      access(vecs[v].d, vecs[v].a, vecs[v].data, vecs[v].oeN, vecs[v].weN,
             wsOf(vecs[v].d) + 1, 0);
      check("vec_dout", {16'd0, dout[vecs[v].d]}, {16'd0, vecs[v].expOut});
    end

    // Write protection: locked write is acked but dropped; set beats clear.
    pulseWp(1'b1, 1'b0);
    access(1, 10'h001, 16'hFFFF, 2'b11, 2'b00, 2, 0);
    access(1, 10'h001, 16'h0000, 2'b00, 2'b11, 2, 0);
    check("wp_read", {16'd0, dout[1]}, 32'h0000);
    pulseWp(1'b1, 1'b1);
    check("wp_both", {31'd0, wpSt[1]}, 32'd1);
    pulseWp(1'b0, 1'b1);

    // Held nCE: nDTACK stays low, no second commit of the changed data.
    access(0, 10'h005, 16'h3C5A, 2'b11, 2'b00, 1, 3);
    access(0, 10'h005, 16'h0000, 2'b00, 2'b11, 1, 0);
    check("hold_ws0", {16'd0, dout[0]}, 32'h3C5A);
    access(2, 10'h009, 16'h5AA5, 2'b11, 2'b00, 4, 3);
    access(2, 10'h009, 16'h0000, 2'b00, 2'b11, 4, 0);
    check("hold_ws3", {16'd0, dout[2]}, 32'h5AA5);

    // Clear sweep length, then an access issued during the sweep.
    for (int i = 0; i < 16; i++) access(2, 10'(i), 16'hBEEF, 2'b11, 2'b00, 4, 0);
    startClear(2);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy[2]) break;
      cnt++;
      @(posedge clk);
      #1;
    end
    check("clear_busy_cycles", cnt, 16);
    for (int i = 0; i < 16; i++) access(2, 10'(i), 16'hBEEF, 2'b11, 2'b00, 4, 0);
    startClear(2);
    for (int i = 0; i < 16; i++) mem[2][i] = 16'h0000;
    access(2, 10'h003, 16'h0000, 2'b00, 2'b11, 16 + 3 + 1, 0);
    check("clear_pending_read", {16'd0, dout[2]}, 32'h0000);
    for (int i = 0; i < 16; i++) access(2, 10'(i), 16'h0000, 2'b00, 2'b11, 4, 0);

    // Reset at word 5 of a sweep keeps the partial result.
    for (int i = 0; i < 16; i++) access(2, 10'(i), 16'hBEEF, 2'b11, 2'b00, 4, 0);
    startClear(2);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_clear_busy", {31'd0, busy[2]}, 32'd0);
    check("rst_mid_clear_dtack", {31'd0, nDtack[2]}, 32'd1);
    for (int i = 0; i < 5; i++) mem[2][i] = 16'h0000;
    for (int d = 0; d < 3; d++) doutM[d] = 16'h0000;
    wpM = 1'b1;
    access(2, 10'h004, 16'h0000, 2'b00, 2'b11, 4, 0);
    check("partial_word4", {16'd0, dout[2]}, 32'h0000);
    access(2, 10'h005, 16'h0000, 2'b00, 2'b11, 4, 0);
    check("partial_word5", {16'd0, dout[2]}, 32'hBEEF);
    for (int i = 0; i < 16; i++) access(2, 10'(i), 16'h0000, 2'b00, 2'b11, 4, 0);

    // Randomized traffic against the model.
    pulseWp(1'b0, 1'b1);
    for (int n = 0; n < 80; n++) begin
      int d;
      logic [1:0] oe;
      logic [1:0] we;
      d = $urandom_range(0, 2);
      oe = 2'($urandom_range(0, 3));
      we = 2'($urandom_range(0, 3));
      if (oe == 2'b11 && we == 2'b11) oe = 2'b00;
      if ($urandom_range(0, 7) == 0) pulseWp(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      access(d, 10'($urandom_range(0, depthOf(d) - 1)), 16'($urandom), oe, we,
             wsOf(d) + 1, $urandom_range(0, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
